posit_extract_pipe: RTL
=======================

// Module: posit_extract_pipe
// PURPOSE
//  Decodes a 32-bit es=2 posit into the serialized value form: sign, scale, fraction, inf, zero.
//  This is the inverse of the sum/product normalizers, which pack the serialized form back into a posit.
//  Sits at the front of the adder/multiplier datapaths.
//  Three-stage elastic pipeline with a valid/ready handshake on both sides.
// PARAMETERS
//  NBITS   32  posit width (fixed; from posit_defines)
//  ES      2   exponent field width (fixed; from posit_defines)
//  FBITS   28  output fraction width, hidden bit included (NBITS-ES-2)
// PORTS
//  clk        in   1    clock
//  reset_n    in   1    synchronous active-low reset
//  in_valid   in   1    in_posit holds a valid posit
//  in_ready   out  1    block accepts in_posit this cycle
//  in_posit   in   32   raw posit word
//  out_valid  out  1    out_value holds a valid result
//  out_ready  in   1    consumer accepts out_value this cycle
//  out_value  out  39   {sgn[38], scale[37:30], fraction[29:2], inf[1], zero[0]}
// BEHAVIOUR
//  - Interface: one clock, clk; synchronous, active-low reset, reset_n.
//  - Reset: all stage valid bits clear, out_valid=0, out_value=0, in_ready=1 on the first cycle after reset.
//  - Handshake:
//    - Transfer occurs when valid&ready are both high.
//    - out_value is held stable while out_valid=1 and out_ready=0.
//    - Stage i loads when !v_i or stage i+1 loads. in_ready = stage-1 load enable.
//    - in_ready is combinational from out_ready, with no skid buffer.
//  - Latency and throughput:
//    - Latency is exactly 3 cycles from accept to out_valid, provided no back-pressure.
//    - Throughput is 1 per cycle. Back-to-back operands are never dropped or duplicated.
//  - S1, register:
//    - sgn = p[31].
//    - zero = (p==0). inf = (p==32'h8000_0000), i.e. NaR.
//    - abs = sgn ? -p : p, using the low 31 bits.
//  - S2, regime, via sub-module:
//    - run = number of identical leading bits of abs[30:0] starting at bit 30, range 1..31.
//    - k = abs[30] ? run-1 : -run.
//    - rem = abs[30:0] << (run+1), zero-filled. A run of 31 leaves rem=0.
//  - S3, assemble:
//    - exp = rem[30:29]; missing bits read as 0.
//    - scale = 4*k + exp, 8-bit two's complement, range -120..+120.
//    - fraction = {1'b1, rem[28:2]}.
//  - Special values:
//    - When zero or inf, out_value carries sgn=inf, scale=0, fraction=0, with the flag set.
//    - zero and inf are never set together.
//  - Arithmetic: no rounding, because the decode is exact. Every 32-bit input pattern is legal.
//  - Reset mid-operation:
//    - Reset with data in flight discards all stages.
//    - No out_valid pulse for discarded data follows deassertion.
//  - out_ready=0 while full: all three stages hold, in_ready=0, and no state changes.
// STRUCTURE
//  - posit_defines (shared package) gains:
//    - POSIT_SERIALIZED_WIDTH_ES2 = 39.
//    - typedef value_es2 {sgn, scale[7:0], fraction[27:0], inf, zero}.
//    - POSIT_NAR = 32'h8000_0000.
//  - Sub-module posit_regime_count:
//    - Combinational: abs[30:0] -> run[4:0], k[6:0] signed, rem[30:0].
//    - Leading-one/zero detector plus barrel shift, reusing the existing shift_left.
//  - Top level holds the three stage registers and the handshake control only.
// TESTING
//  - 32'h4000_0000 -> sgn=0, scale=0, fraction=28'h800_0000, inf=0, zero=0; out_valid in cycle 3.
//  - 32'h4800_0000 -> scale=+1 (k=0, exp=01), fraction=28'h800_0000.
//    32'hC000_0000 -> sgn=1, scale=0.
//  - Extremes:
//    - 32'h7FFF_FFFF -> scale=+120, fraction=28'h800_0000.
//    - 32'h0000_0001 -> scale=-120.
//  - Specials:
//    - 32'h0000_0000 -> zero=1, out_value=39'h1.
//    - 32'h8000_0000 -> inf=1, sgn=1, out_value=39'h40_0000_0002.
//  - Back-pressure: stream 8 posits with out_ready toggling 1,0,0,1...
//    -> all 8 emerge in order, unchanged; in_ready=0 only when all stages are full.
//  - Reset mid-stream: 2 posits in flight, reset_n low for 1 cycle
//    -> out_valid=0 for 3 cycles; the next input emerges with latency 3.

Source files
------------

// File: rtl/posit_extract_pipe_pkg.sv
// Shared posit definitions for the es=2, 32-bit datapath: widths, NaR,
// the serialized value layout and the pipeline stage payloads.
package posit_extract_pipe_pkg;

  localparam int unsigned NBITS = 32;
  localparam int unsigned ES    = 2;
  localparam int unsigned FBITS = NBITS - ES - 2;

  localparam int unsigned POSIT_SERIALIZED_WIDTH_ES2 = 39;
  localparam logic [NBITS-1:0] POSIT_NAR = 32'h8000_0000;

  typedef struct packed {
    logic             sgn;
    logic [7:0]       scale;
    logic [FBITS-1:0] fraction;
    logic             inf;
    logic             zero;
  } value_es2;

  typedef struct packed {
    logic        sgn;
    logic        zero;
    logic        inf;
    logic [30:0] abs;
  } s1_t;

  typedef struct packed {
    logic               sgn;
    logic               zero;
    logic               inf;
    logic signed [6:0]  k;
    logic [30:0]        rem;
  } s2_t;

  function automatic logic [30:0] shift_left(input logic [30:0] data,
                                             input logic [5:0]  amt);
    return data << amt;
  endfunction

endpackage

// File: rtl/posit_regime_count.sv
// Regime decode: length of the leading run in abs[30:0], the signed regime
// value k, and the bits left after the run and its terminator.
module posit_regime_count
  import posit_extract_pipe_pkg::*;
(
  input  logic [30:0]       abs,
  output logic [4:0]        run,
  output logic signed [6:0] k,
  output logic [30:0]       rem
);

  logic [30:0] x;
  logic        done;

  always_comb begin
    // Invert a run of ones so both regime polarities become a leading-zero count.
    x    = abs[30] ? ~abs : abs;
    run  = 5'd31;
    done = 1'b0;
    for (int unsigned i = 0; i < 31; i++) begin
      if (!done && x[5'(30 - i)]) begin
        run  = 5'(i);
        done = 1'b1;
      end
    end
    k   = abs[30] ? (signed'({2'b00, run}) - 7'sd1) : -signed'({2'b00, run});
    rem = shift_left(abs, {1'b0, run} + 6'd1);
  end

endmodule

// File: rtl/posit_extract_pipe.sv
// Three-stage elastic decoder from a 32-bit es=2 posit to the serialized
// {sgn, scale, fraction, inf, zero} form used by the adder/multiplier.
module posit_extract_pipe
  import posit_extract_pipe_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NBITS-1:0]                      in_posit,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] out_value
);

  logic     v1, v2, v3;
  logic     ld1, ld2, ld3;
  s1_t      s1_q, s1_d;
  s2_t      s2_q, s2_d;
  value_es2 s3_q, s3_d;

  logic [30:0]       neg_low;
  logic [4:0]        regime_run;
  logic signed [6:0] regime_k;
  logic [30:0]       regime_rem;
  logic signed [7:0] k8;
  logic              unused_ok;

  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  // The low 31 bits of -p equal the negation of p[30:0] modulo 2^31.
  assign neg_low = -in_posit[30:0];

  always_comb begin
    s1_d      = '0;
    s1_d.sgn  = in_posit[31];
    s1_d.zero = (in_posit == '0);
    s1_d.inf  = (in_posit == POSIT_NAR);
    s1_d.abs  = in_posit[31] ? neg_low : in_posit[30:0];
  end

  posit_regime_count u_regime (
    .abs (s1_q.abs),
    .run (regime_run),
    .k   (regime_k),
    .rem (regime_rem)
  );

  always_comb begin
    s2_d      = '0;
    s2_d.sgn  = s1_q.sgn;
    s2_d.zero = s1_q.zero;
    s2_d.inf  = s1_q.inf;
    s2_d.k    = regime_k;
    s2_d.rem  = regime_rem;
  end

  assign unused_ok = ^{regime_run, s2_q.rem[1:0]};

  always_comb begin
    k8   = {s2_q.k[6], s2_q.k};
    s3_d = '0;
    if (s2_q.zero || s2_q.inf) begin
      s3_d.sgn  = s2_q.inf;
      s3_d.inf  = s2_q.inf;
      s3_d.zero = s2_q.zero;
    end else begin
      s3_d.sgn      = s2_q.sgn;
      s3_d.scale    = (k8 <<< 2) | {6'b0, s2_q.rem[30:29]};
      s3_d.fraction = {1'b1, s2_q.rem[28:2]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (ld1 && in_valid) s1_q <= s1_d;
      if (ld2 && v1)       s2_q <= s2_d;
      if (ld3 && v2)       s3_q <= s3_d;
    end
  end

  assign out_valid = v3;
  assign out_value = s3_q;

endmodule
